// File: rtl/mips_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the architectural HI/LO registers.
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring), one bit per cycle,
// and takes MTHI/MTLO writes directly while idle.
module mips_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] rs_q;
    logic [WIDTH-1:0] rt_q;
    logic [WIDTH-1:0] mcand;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc;      // upper product half or partial remainder
    logic [WIDTH-1:0] work;     // multiplier/lower product or dividend/quotient
    logic             sign_q;
    logic             sign_r;
    logic [CNT_W-1:0] cnt;

    logic             is_div;
    logic             is_sgn;
    logic             div_zero;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] hi_res;
    logic [WIDTH-1:0] lo_res;

    assign is_div   = op_q[1];
    assign is_sgn   = op_q[0];
    assign div_zero = is_div && (rt_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = PREP;
            PREP: state_nxt = div_zero ? FIX : CALC;
            CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-iteration step values and final HI/LO results
    always_comb begin
        mul_sum   = {1'b0, acc} + (work[0] ? {1'b0, mcand} : (WIDTH + 1)'(0));
        div_shift = {acc, work[MSB]};
        div_trial = div_shift - {1'b0, mcand};
        prod_fix  = {acc, work};
        hi_res    = acc;
        lo_res    = work;
        if (is_sgn && sign_q) begin
            prod_fix = PW'(0) - {acc, work};
        end
        if (div_zero) begin
            hi_res = rs_q;
            lo_res = '1;
        end else if (is_div) begin
            lo_res = (is_sgn && sign_q) ? WIDTH'(0) - work : work;
            hi_res = (is_sgn && sign_r) ? WIDTH'(0) - acc  : acc;
        end else begin
            hi_res = prod_fix[PW-1:WIDTH];
            lo_res = prod_fix[WIDTH-1:0];
        end
    end

    // Datapath, HI/LO and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            mcand  <= '0;
            acc    <= '0;
            work   <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        rs_q <= rs;
                        rt_q <= rt;
                        busy <= 1'b1;
                    end else begin
                        if (mthi) hi <= rs;
                        if (mtlo) lo <= rs;
                    end
                end
                PREP: begin
                    sign_q <= is_sgn && (rs_q[MSB] ^ rt_q[MSB]);
                    sign_r <= is_sgn && rs_q[MSB];
                    work   <= (is_sgn && rs_q[MSB]) ? WIDTH'(0) - rs_q : rs_q;
                    mcand  <= (is_sgn && rt_q[MSB]) ? WIDTH'(0) - rt_q : rt_q;
                    acc    <= '0;
                    cnt    <= '0;
                end
                CALC: begin
                    if (is_div) begin
                        // Restoring step: keep the trial difference only if non-negative
                        if (!div_trial[WIDTH]) begin
                            acc  <= div_trial[WIDTH-1:0];
                            work <= {work[MSB-1:0], 1'b1};
                        end else begin
                            acc  <= div_shift[WIDTH-1:0];
                            work <= {work[MSB-1:0], 1'b0};
                        end
                    end else begin
                        acc  <= mul_sum[WIDTH:1];
                        work <= {mul_sum[0], work[MSB:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    hi   <= hi_res;
                    lo   <= lo_res;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit.
module tb_mips_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    mips_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request at the current negedge; accepted at the next rising edge (E0)
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic with_mtlo);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        mtlo  = with_mtlo;
    endtask

    // Wait for done; 'elapsed' negedges since E0 already passed. Latency counted
    // in negedges after E0 (done after E34 -> 35, after E2 -> 3).
    task automatic finish_op(input string tag, input int elapsed, input int exp_lat,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat = 0;
        bit busy_ok = 1'b1;
        for (int i = elapsed + 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                mtlo  = 1'b0;
                rs    = 32'h5A5A5A5A;
                rt    = 32'h00000003;
            end
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        chk({tag, "_lat"},  64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        rs    = '0;
        rt    = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MTHI+MTLO together, then MTHI alone
        mthi = 1'b1; mtlo = 1'b1; rs = 32'h13572468;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both_hi", 64'(hi), 64'h13572468);
        chk("mt_both_lo", 64'(lo), 64'h13572468);
        mthi = 1'b1; rs = 32'hAAAA5555;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_hi", 64'(hi), 64'hAAAA5555);
        chk("mthi_lo", 64'(lo), 64'h13572468);

        // MULTU max x max
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        finish_op("multu_max", 0, 35, 32'hFFFFFFFE, 32'h00000001);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);

        issue(OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
        finish_op("mult_neg", 0, 35, 32'hFFFFFFFF, 32'hFFFFFFEB);
        @(negedge clk);
        issue(OP_MULT, 32'h80000000, 32'h80000000, 1'b0);
        finish_op("mult_min", 0, 35, 32'h40000000, 32'h00000000);
        @(negedge clk);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        finish_op("div_neg", 0, 35, 32'hFFFFFFFF, 32'hFFFFFFFD);
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
        finish_op("divu", 0, 35, 32'd2, 32'd14);
        @(negedge clk);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        finish_op("div_ovf", 0, 35, 32'h00000000, 32'h80000000);
        @(negedge clk);

        // MTHI/MTLO while busy are ignored
        issue(OP_MULTU, 32'd3, 32'd5, 1'b0);
        @(negedge clk);
        start = 1'b0; mthi = 1'b1; mtlo = 1'b1; rs = 32'hDEADBEEF;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("busy_wr_hi", 64'(hi), 64'h00000000);
        chk("busy_wr_lo", 64'(lo), 64'h80000000);
        finish_op("mult_busywr", 2, 35, 32'd0, 32'd15);
        @(negedge clk);

        // start with mtlo in the same cycle: write dropped, op runs
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        chk("start_mtlo_lo",   64'(lo),   64'd15);
        chk("start_mtlo_busy", 64'(busy), 64'd1);
        finish_op("divu_mtlo", 1, 35, 32'd2, 32'd14);
        @(negedge clk);

        // Zero divisor, then back-to-back start in the done cycle
        issue(OP_DIVU, 32'h00001234, 32'd0, 1'b0);
        finish_op("divu_zero", 0, 3, 32'h00001234, 32'hFFFFFFFF);
        issue(OP_MULTU, 32'd2, 32'd3, 1'b0);
        finish_op("b2b_multu", 0, 35, 32'd0, 32'd6);
        @(negedge clk);

        // Reset in the middle of an operation
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hi",   64'(hi),   64'd0);
        chk("midrst_lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(OP_MULTU, 32'd6, 32'd7, 1'b0);
        finish_op("post_rst", 0, 35, 32'd0, 32'd42);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Iterative multi-cycle multiply/divide unit that executes MULT, MULTU, DIV and DIVU for the MIPS core. It owns the architectural HI/LO registers. The ALU/control path issues a request with a start pulse and reads HI/LO back for MFHI/MFLO. MTHI/MTLO write HI/LO directly, which removes HI/LO storage from the ALU.

Parameters:
WIDTH, 32, operand and HI/LO width; only 32 is supported.
CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request strobe; sampled only in IDLE.
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
rs  input  WIDTH  operand A (multiplicand/dividend).
rt  input  WIDTH  operand B (multiplier/divisor).
mthi  input  1  write rs into HI.
mtlo  input  1  write rs into LO.
busy  output  1  high from the edge after start is accepted until the result-write edge.
done  output  1  one-cycle pulse, registered with the HI/LO result write.
hi  output  WIDTH  HI register (remainder or upper product).
lo  output  WIDTH  LO register (quotient or lower product).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0. Reset mid-operation aborts the operation, and no partial result is ever written.
- States: IDLE, PREP, CALC, FIX.
- IDLE:
  - start=1 at edge E0: latch op, rs, rt; go to PREP; busy=1 after E0.
  - Otherwise, mthi/mtlo write rs into hi/lo at the edge. Both may be asserted together, and both are written.
- Priority in IDLE: start beats mthi/mtlo. A write in the same cycle as start is dropped.
- PREP (edge E1):
  - For signed ops (op[0]=1), take the absolute values of the operands. Record sign_q = rs[31]^rt[31] and sign_r = rs[31].
  - Unsigned ops use operands as-is.
  - Divide with rt==0 goes directly to FIX with the zero-divisor result. Otherwise go to CALC with counter=0.
- CALC: one iteration per cycle, 32 iterations (edges E2..E33). At counter==31, go to FIX.
  - Multiply: shift-add, producing a 64-bit unsigned product {acc, mplier}.
  - Divide: restoring, one quotient bit per cycle; remainder 32 bits, trial subtract 33 bits.
- FIX (edge E34 normal, E2 on zero divisor):
  - Write hi/lo, set done=1, busy=0, go to IDLE.
  - Multiply: if signed and sign_q, negate the full 64-bit product. Then hi=product[63:32], lo=product[31:0].
  - Divide: lo=quotient, negated if signed and sign_q; hi=remainder, negated if signed and sign_r.
  - Zero divisor (both DIVU and DIV): lo=32'hFFFFFFFF, hi=rs as originally presented (unmodified).
- Latency: done is high in the cycle following edge E34 (E2 for zero divisor), and hi/lo hold the new values in that same cycle.
- done: deasserts at the next edge.
- Back-to-back requests: start is accepted in the same cycle that done is high, since state is IDLE.
- While busy:
  - start, mthi and mtlo are ignored.
  - hi/lo keep their old values until the FIX edge.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This falls out of the abs/negate path with no special case.
- Operand registers: rs/rt may change after E0 without affecting the result.

Test Plan:
- MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF, start at E0 -> busy high for E0..E34; done pulse after E34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT: rs=-3 (0xFFFFFFFD), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV: rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU: rs=100, rt=7 -> lo=14, hi=2. DIV: 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU: rs=0x00001234, rt=0 -> done after E2, lo=0xFFFFFFFF, hi=0x00001234; next start is accepted in the done cycle.
- MTHI with rs=0xAAAA5555 in IDLE -> hi=0xAAAA5555. Same write during busy -> ignored. start+mtlo in the same cycle -> mtlo dropped, operation runs.
- Reset with rst_n low at cycle 10 of a MULTU -> immediate busy=0, done=0, hi=lo=0. After release, a fresh MULTU 6×7 gives lo=42, hi=0.
